io_port_bridge: RTL and testbench

CPU-side end of the peripheral byte-stream interface that the value-storage I/O device speaks. Receives bytes the device offers (value + trigger, gated by our ready) into a small RX FIFO, and sends CPU-written bytes to the device as one-cycle value + trigger pulses. Sits between the RISC-V core's memory-mapped I/O decode and the device. Exposes three 32-bit registers on a simple one-cycle bus.

---
 rtl/io_port_bridge.sv | 177 +++++++++++++++++
 tb/tb_io_port_bridge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// CPU-side byte-stream bridge: RX FIFO, TX pulse FSM, DATA/STATUS/CONTROL regs; IO_PORT_BRIDGE_LOOPBACK_EN adds loopback.
// Latency: bus reads 1 cycle; TX pulse on the cycle after an accepted DATA write, then TX_GAP idle cycles.
// Backpressure: dev_input_ready drops when the RX FIFO is full; DATA writes while TX is busy are dropped and flagged.
module io_port_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int TX_GAP     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_write_trigger,
  input  logic        bus_read_trigger,
  input  logic [1:0]  bus_address,
  input  logic [31:0] bus_write_value,
  output logic [31:0] bus_read_value,
  output logic        bus_read_valid,
  output logic [7:0]  dev_output_value,
  output logic        dev_output_trigger,
  input  logic [7:0]  dev_input_value,
  input  logic        dev_input_trigger,
  output logic        dev_input_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(TX_GAP - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} tx_state_t;

  tx_state_t       state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            tx_drop_q, rx_underrun_q;
  logic [31:0]     rd_mux;
  logic            loopback;

  logic rx_full, rx_nonempty, wr_data, wr_status, wr_ctrl, rd_data;
  logic tx_accept, rx_flush, dev_push, lb_push, lb_drop, push, pop;
  logic [7:0] push_dat;
  logic unused_bits;

  assign unused_bits = ^bus_write_value[31:8];

  assign rx_full     = (count_q == FULL_CNT);
  assign rx_nonempty = (count_q != '0);

  assign wr_data   = bus_write_trigger && (bus_address == A_DATA);
  assign wr_status = bus_write_trigger && (bus_address == A_STATUS);
  assign wr_ctrl   = bus_write_trigger && (bus_address == A_CTRL);
  assign rd_data   = bus_read_trigger  && (bus_address == A_DATA);

  assign tx_accept = wr_data && (state_q == ST_IDLE);
  assign rx_flush  = wr_ctrl && bus_write_value[0];

`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
  logic loopback_q;
  assign loopback = loopback_q;
  // Loopback bytes enter at write acceptance; a full FIFO drops them.
  assign lb_push  = loopback_q && tx_accept && !rx_full;
  assign lb_drop  = loopback_q && tx_accept && rx_full;
`else
  assign loopback = 1'b0;
  assign lb_push  = 1'b0;
  assign lb_drop  = 1'b0;
`endif

  assign dev_input_ready = !rx_full && !loopback;
  assign dev_push        = dev_input_trigger && dev_input_ready;
  assign push            = dev_push || lb_push;
  assign push_dat        = lb_push ? bus_write_value[7:0] : dev_input_value;
  assign pop             = rd_data && rx_nonempty;

  always_comb begin
    state_d            = state_q;
    gap_d              = gap_q;
    dev_output_trigger = 1'b0;
    case (state_q)
      ST_IDLE: if (tx_accept) state_d = ST_SEND;
      ST_SEND: begin
        dev_output_trigger = !loopback;
        if (TX_GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_LAST;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (bus_address)
      A_DATA:   if (rx_nonempty) rd_mux[7:0] = mem[rd_ptr_q];
      A_STATUS: begin
        rd_mux[0]    = rx_nonempty;
        rd_mux[1]    = rx_full;
        rd_mux[2]    = (state_q != ST_IDLE);
        rd_mux[3]    = tx_drop_q;
        rd_mux[4]    = rx_underrun_q;
        rd_mux[12:8] = 5'(count_q);
      end
      A_CTRL:   rd_mux[1] = loopback;
      default:  rd_mux = 32'd0;
    endcase
  end

  // FIFO storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      tx_drop_q        <= 1'b0;
      rx_underrun_q    <= 1'b0;
      dev_output_value <= 8'd0;
      bus_read_value   <= 32'd0;
      bus_read_valid   <= 1'b0;
`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
      loopback_q       <= 1'b0;
`endif
    end else begin
      bus_read_valid <= bus_read_trigger;
      if (bus_read_trigger) bus_read_value <= rd_mux;

      if (rx_flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end

      if (tx_accept && !loopback) dev_output_value <= bus_write_value[7:0];

      if ((wr_data && state_q != ST_IDLE) || lb_drop) tx_drop_q <= 1'b1;
      else if (wr_status && bus_write_value[3])      tx_drop_q <= 1'b0;

      if (rd_data && !rx_nonempty)                 rx_underrun_q <= 1'b1;
      else if (wr_status && bus_write_value[4])    rx_underrun_q <= 1'b0;

`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
      if (wr_ctrl) loopback_q <= bus_write_value[1];
`endif
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed plus randomized bench for io_port_bridge against a queue-based reference model.
module tb_io_port_bridge;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_write_trigger, bus_read_trigger;
  logic [1:0]  bus_address;
  logic [31:0] bus_write_value, bus_read_value;
  logic        bus_read_valid;
  logic [7:0]  dev_output_value, dev_input_value;
  logic        dev_output_trigger, dev_input_trigger, dev_input_ready;

  always #5 clk = ~clk;

  io_port_bridge #(.FIFO_DEPTH(DEPTH), .TX_GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .bus_write_trigger(bus_write_trigger), .bus_read_trigger(bus_read_trigger),
    .bus_address(bus_address), .bus_write_value(bus_write_value),
    .bus_read_value(bus_read_value), .bus_read_valid(bus_read_valid),
    .dev_output_value(dev_output_value), .dev_output_trigger(dev_output_trigger),
    .dev_input_value(dev_input_value), .dev_input_trigger(dev_input_trigger),
    .dev_input_ready(dev_input_ready)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: RX contents, bytes the device still wants to send, TX pulse timeline.
  logic [7:0]  mq[$];
  logic [7:0]  dq[$];
  int          cyc = 0;
  int          last_send = -100;
  bit          drop, und, lb;
  logic [7:0]  ov;
  logic [31:0] last_rd;

  function automatic bit m_busy();
    return cyc <= last_send + GAP;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d, input bit rst);
    logic [31:0] exp_rd;
    bit full, lb0, pushd;
    reset             = rst;
    bus_read_trigger  = r;
    bus_write_trigger = w;
    bus_address       = a;
    bus_write_value   = d;
    dev_input_trigger = (dq.size() > 0);
    dev_input_value   = (dq.size() > 0) ? dq[0] : 8'h00;
    lb0  = lb;
    full = (mq.size() == DEPTH);
    if (!rst) chk("ready", 32'(dev_input_ready), 32'(!full && !lb0));
    case (a)
      2'd0:    exp_rd = (mq.size() > 0) ? {24'b0, mq[0]} : 32'd0;
      2'd1:    exp_rd = {19'b0, 5'(mq.size()), 3'b0, und, drop, m_busy(), full, mq.size() > 0};
      2'd2:    exp_rd = {30'b0, lb0, 1'b0};
      default: exp_rd = 32'd0;
    endcase
    if (!rst) begin
      pushd = dev_input_trigger && !full && !lb0;
      if (r && a == 2'd0) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else               und = 1'b1;
      end
      if (pushd) mq.push_back(dq.pop_front());
      if (w && a == 2'd0) begin
        if (m_busy()) drop = 1'b1;
        else begin
          last_send = cyc + 1;
          if (lb0) begin
            if (full) drop = 1'b1;
            else      mq.push_back(d[7:0]);
          end else ov = d[7:0];
        end
      end
      if (w && a == 2'd2 && d[0]) mq.delete();
      if (w && a == 2'd1) begin
        if (d[3]) drop = 1'b0;
        if (d[4]) und  = 1'b0;
      end
`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
      if (w && a == 2'd2) lb = d[1];
`endif
    end else begin
      mq.delete();
      last_send = -100;
      drop = 1'b0; und = 1'b0; lb = 1'b0; ov = 8'h00;
    end
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      chk("rst_valid", 32'(bus_read_valid), 32'd0);
      chk("rst_value", bus_read_value, 32'd0);
    end else begin
      chk("rd_valid", 32'(bus_read_valid), 32'(r));
      if (r) chk("rd_value", bus_read_value, exp_rd);
    end
    chk("tx_trig", 32'(dev_output_trigger), 32'(cyc == last_send && !lb));
    chk("tx_value", 32'(dev_output_value), 32'(ov));
    last_rd = bus_read_value;
  endtask

  task automatic idle();                                 step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0); endtask
  task automatic rd(input logic [1:0] a);                step(1'b1, 1'b0, a, 32'd0, 1'b0);    endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); step(1'b0, 1'b1, a, d, 1'b0); endtask
  task automatic rst_cycle();                            step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1); endtask

  initial begin
    reset = 1'b1; bus_write_trigger = 1'b0; bus_read_trigger = 1'b0;
    bus_address = 2'd0; bus_write_value = 32'd0;
    dev_input_value = 8'd0; dev_input_trigger = 1'b0;
    #2;
    rst_cycle(); rst_cycle();

    rd(2'd1);
    chk("status_after_reset", last_rd, 32'h0);
    idle();

    dq.push_back(8'd22); dq.push_back(8'd40); dq.push_back(8'd7);
    repeat (4) idle();
    rd(2'd1); chk("count3", 32'(last_rd[12:8]), 32'd3);
    rd(2'd0); chk("rx_22", last_rd, 32'd22);
    rd(2'd0); chk("rx_40", last_rd, 32'd40);
    rd(2'd0); chk("rx_7",  last_rd, 32'd7);
    rd(2'd0); chk("rx_empty", last_rd, 32'd0);
    rd(2'd1); chk("underrun", 32'(last_rd[4]), 32'd1);
    wr(2'd1, 32'h10);

    for (int i = 1; i <= 5; i++) dq.push_back(8'(i));
    repeat (6) idle();
    chk("full_ready", 32'(dev_input_ready), 32'd0);
    rd(2'd0); chk("full_head", last_rd, 32'd1);
    idle();
    for (int i = 2; i <= 5; i++) begin
      rd(2'd0); chk("full_order", last_rd, 32'(i));
    end

    wr(2'd0, 32'h1A5);
    chk("tx_pulse", 32'(dev_output_trigger), 32'd1);
    chk("tx_byte", 32'(dev_output_value), 32'hA5);
    wr(2'd0, 32'h77);
    chk("tx_pulse_end", 32'(dev_output_trigger), 32'd0);
    idle();
    wr(2'd0, 32'h5A);
    wr(2'd0, 32'h3C);
    chk("tx_after_gap", 32'(dev_output_trigger), 32'd1);
    rd(2'd1); chk("tx_drop_set", 32'(last_rd[3]), 32'd1);
    wr(2'd1, 32'h8);
    rd(2'd1); chk("tx_drop_clr", 32'(last_rd[3]), 32'd0);

    wr(2'd2, 32'h1);
    dq.push_back(8'd10); dq.push_back(8'd11);
    repeat (3) idle();
    dq.push_back(8'd12);
    rd(2'd0); chk("pushpop_head", last_rd, 32'd10);
    rd(2'd1); chk("pushpop_count", 32'(last_rd[12:8]), 32'd2);
    dq.push_back(8'd99);
    wr(2'd2, 32'h1);
    rd(2'd1); chk("flush_count", 32'(last_rd[12:8]), 32'd0);

    repeat (4) idle();
    wr(2'd0, 32'hEE);
    rst_cycle();
    chk("rst_cut_pulse", 32'(dev_output_trigger), 32'd0);
    idle(); idle();

    repeat (400) begin
      bit r, w;
      logic [1:0] a;
      logic [31:0] d;
      if ($urandom_range(0, 3) == 0 && dq.size() < 3) dq.push_back(8'($urandom));
      r = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd2 && $urandom_range(0, 7) != 0) d[0] = 1'b0;
      step(r, w, a, d, 1'b0);
    end

`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
    dq.delete();
    wr(2'd2, 32'h1);
    repeat (4) idle();
    wr(2'd2, 32'h2);
    wr(2'd0, 32'h33);
    chk("lb_no_trig", 32'(dev_output_trigger), 32'd0);
    repeat (3) idle();
    rd(2'd0); chk("lb_data", last_rd, 32'h33);
    wr(2'd2, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
